// File: rtl/mmio_uart_io_unit_pkg.sv
// Register map, bit positions and TX drain state encoding shared by the
// memory-mapped UART/LED I/O unit.
package io_map_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  localparam int unsigned ST_RX_NE   = 0;
  localparam int unsigned ST_RX_FULL = 1;
  localparam int unsigned ST_TX_EMPT = 2;
  localparam int unsigned ST_TX_FULL = 3;
  localparam int unsigned ST_TX_OVF  = 4;
  localparam int unsigned ST_RX_OVR  = 5;
  localparam int unsigned ST_TX_IDLE = 6;

  localparam int unsigned CTRL_RX_IE = 0;
  localparam int unsigned CTRL_TX_IE = 1;

  localparam int unsigned CLR_TX_OVF = 4;
  localparam int unsigned CLR_RX_OVR = 5;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_PULSE = 2'd1,
    TX_HOLD  = 2'd2,
    TX_WAIT  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_io_unit_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Head is read combinationally before this edge, so overwriting the
  // head slot on a full push+pop is safe.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_io_unit.sv
// Memory-mapped UART/LED I/O unit on the MEM-stage data port: TX FIFO with
// autonomous drain FSM, edge-captured RX FIFO, sticky errors, IRQ, LEDs.
module mmio_uart_io_unit
  import io_map_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = 32'h1000_0000,
  parameter logic [31:0] LED_ADDR = 32'h2000_0000,
  parameter int unsigned LED_W    = 16,
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic             bus_we,
  input  logic             bus_re,
  output logic             bus_hit,
  output logic [31:0]      bus_rdata,
  output logic [LED_W-1:0] led_out,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_we,
  input  logic             uart_tx_busy,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid,
  output logic             uart_rx_re,
  output logic             irq
);

  tx_state_e        state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic             tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
  logic             rx_prev_q, rx_re_q, rx_re_d, irq_q, irq_d;

  logic [31:0] uart_off;
  logic        uart_hit, led_hit, rd_en, tx_idle;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_dout, rx_dout;
  logic [6:0]  status;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic        unused_bits;

  assign uart_off = bus_addr - IO_BASE;
  assign uart_hit = (uart_off < 32'd16);
  assign led_hit  = (bus_addr == LED_ADDR);
  assign bus_hit  = uart_hit | led_hit;
  assign rd_en    = bus_re & ~bus_we;
  assign tx_idle  = (state_q == TX_IDLE) & tx_empty;
  assign rx_push  = uart_rx_valid & ~rx_prev_q;
  assign status   = {tx_idle, rx_ovr_q, tx_ovf_q, tx_full, tx_empty, rx_full, ~rx_empty};
  assign unused_bits = ^{tx_count, rx_count, uart_off[31:4], uart_off[1:0], bus_wdata};

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus_wdata[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(uart_rx_data),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_pop    = 1'b0;
    unique case (state_q)
      TX_IDLE: if (!tx_empty && !uart_tx_busy) begin
        tx_pop    = 1'b1;
        tx_data_d = tx_dout;
        state_d   = TX_PULSE;
      end
      TX_PULSE: state_d = TX_HOLD;
      TX_HOLD:  state_d = TX_WAIT;
      TX_WAIT:  if (!uart_tx_busy) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_push  = 1'b0;
    rx_pop   = 1'b0;
    ctrl_d   = ctrl_q;
    led_d    = led_q;
    tx_ovf_d = tx_ovf_q;
    rx_ovr_d = rx_ovr_q;
    rdata_d  = '0;
    if (bus_we && uart_hit) begin
      unique case (uart_off[3:2])
        REG_DATA:  tx_push = 1'b1;
        REG_CTRL:  ctrl_d = bus_wdata[1:0];
        REG_CLEAR: begin
          if (bus_wdata[CLR_TX_OVF]) tx_ovf_d = 1'b0;
          if (bus_wdata[CLR_RX_OVR]) rx_ovr_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (bus_we && led_hit) led_d = bus_wdata[LED_W-1:0];
    if (rd_en && uart_hit) begin
      unique case (uart_off[3:2])
        REG_DATA: if (!rx_empty) begin
          rx_pop  = 1'b1;
          rdata_d = {24'd0, rx_dout};
        end
        REG_STATUS: rdata_d = 32'(status);
        REG_CTRL:   rdata_d = {30'd0, ctrl_q};
        default: ;
      endcase
    end
    if (rd_en && led_hit) rdata_d = 32'(led_q);
    // Sticky errors only when the byte is really lost (no same-cycle pop).
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_push && rx_full && !rx_pop) rx_ovr_d = 1'b1;
    rx_re_d = rx_push;
    irq_d   = (ctrl_q[CTRL_RX_IE] & ~rx_empty) |
              (ctrl_q[CTRL_TX_IE] & tx_empty & tx_idle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      tx_data_q <= '0;
      rdata_q   <= '0;
      led_q     <= '0;
      ctrl_q    <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      rx_prev_q <= 1'b0;
      rx_re_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      ctrl_q    <= ctrl_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovr_q  <= rx_ovr_d;
      rx_prev_q <= uart_rx_valid;
      rx_re_q   <= rx_re_d;
      irq_q     <= irq_d;
    end
  end

  assign uart_tx_we   = (state_q == TX_PULSE);
  assign uart_tx_data = tx_data_q;
  assign uart_rx_re   = rx_re_q;
  assign bus_rdata    = rdata_q;
  assign led_out      = led_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_mmio_uart_io_unit.sv
// Self-checking bench for mmio_uart_io_unit: directed sequences, a register
// vector table and a randomized phase checked against queue-based models.
module tb_mmio_uart_io_unit;

  localparam logic [31:0] IO_BASE  = 32'h1000_0000;
  localparam logic [31:0] LED_ADDR = 32'h2000_0000;
  localparam int unsigned LED_W    = 16;
  localparam int unsigned TX_DEPTH = 16;
  localparam int unsigned RX_DEPTH = 16;
  localparam logic [31:0] A_DATA = IO_BASE, A_STAT = IO_BASE + 4;
  localparam logic [31:0] A_CTRL = IO_BASE + 8, A_CLR = IO_BASE + 12;

  logic clk, rst, bus_we, bus_re, bus_hit, uart_tx_we, uart_tx_busy;
  logic uart_rx_valid, uart_rx_re, irq;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [LED_W-1:0] led_out;
  logic [7:0] uart_tx_data, uart_rx_data;

  int n_cmp = 0, n_bad = 0, cyc = 0, rx_re_cnt = 0;
  logic [7:0] tx_seen[$];
  int strobe_cyc[$];

  mmio_uart_io_unit #(.IO_BASE(IO_BASE), .LED_ADDR(LED_ADDR), .LED_W(LED_W),
                      .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_hit(bus_hit), .bus_rdata(bus_rdata),
    .led_out(led_out), .uart_tx_data(uart_tx_data), .uart_tx_we(uart_tx_we),
    .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_re(uart_rx_re), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && uart_tx_we) begin
      tx_seen.push_back(uart_tx_data);
      strobe_cyc.push_back(cyc);
    end
    if (!rst && uart_rx_re) rx_re_cnt++;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        exp_hit;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    @(negedge clk);
    bus_we = 1'b0; bus_addr = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_re = 1'b1;
    @(negedge clk);
    bus_re = 1'b0; bus_addr = '0;
    d = bus_rdata;
  endtask

  task automatic rx_inject(input logic [7:0] b);
    @(negedge clk);
    uart_rx_data = b; uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (tx_seen.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("strobe_count", tx_seen.size(), target);
  endtask

  function automatic logic [31:0] model_status(input int ntx, input int nrx,
                                               input bit ovf, input bit ovr);
    logic [31:0] s = '0;
    s[0] = (nrx != 0);
    s[1] = (nrx == RX_DEPTH);
    s[2] = (ntx == 0);
    s[3] = (ntx == TX_DEPTH);
    s[4] = ovf;
    s[5] = ovr;
    s[6] = (ntx == 0);
    return s;
  endfunction

  initial begin
    logic [31:0] rd;
    int base, re0;
    vec_t vt[$];
    logic [7:0] mtx[$], mrx[$];
    bit movf, movr;
    int n_inj;

    rst = 1'b0; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
    uart_tx_busy = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0;
    #2 rst = 1'b1;
    #2;
    check("rst_tx_we", 32'(uart_tx_we), 0);
    check("rst_tx_data", 32'(uart_tx_data), 0);
    check("rst_rx_re", 32'(uart_rx_re), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_rdata", bus_rdata, 0);
    check("rst_led", 32'(led_out), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_read(A_STAT, rd); check("rst_status", rd, 32'h44);

    // Two bytes drained back to back with busy low.
    base = tx_seen.size();
    bus_write(A_DATA, 32'h41);
    bus_write(A_DATA, 32'h42);
    wait_strobes(base + 2, 50);
    if (tx_seen.size() >= base + 2) begin
      check("tx_byte0", 32'(tx_seen[base]), 32'h41);
      check("tx_byte1", 32'(tx_seen[base+1]), 32'h42);
      check("tx_strobe_period", strobe_cyc[base+1] - strobe_cyc[base], 4);
    end
    repeat (5) @(negedge clk);
    bus_read(A_STAT, rd); check("tx_idle_status", rd, 32'h44);

    // Overfill TX while the transmitter is busy.
    uart_tx_busy = 1'b1;
    base = tx_seen.size();
    for (int i = 0; i <= TX_DEPTH; i++) bus_write(A_DATA, 32'(8'h50 + i));
    bus_read(A_STAT, rd); check("tx_full_ovf_status", rd, 32'h18);
    check("no_strobe_busy", tx_seen.size(), base);
    uart_tx_busy = 1'b0;
    wait_strobes(base + TX_DEPTH, 300);
    repeat (20) @(negedge clk);
    check("tx_exact_count", tx_seen.size(), base + TX_DEPTH);
    for (int i = 0; i < TX_DEPTH; i++)
      if (base + i < tx_seen.size()) check("tx_order", 32'(tx_seen[base+i]), 32'(8'h50 + i));
    bus_write(A_CLR, 32'h10);
    bus_read(A_STAT, rd); check("tx_ovf_cleared", rd, 32'h44);

    // Three received bytes, then empty read.
    re0 = rx_re_cnt;
    rx_inject(8'h11); rx_inject(8'h22); rx_inject(8'h33);
    @(negedge clk);
    check("rx_re_pulses", rx_re_cnt - re0, 3);
    bus_read(A_DATA, rd); check("rx_rd0", rd, 32'h11);
    bus_read(A_DATA, rd); check("rx_rd1", rd, 32'h22);
    bus_read(A_DATA, rd); check("rx_rd2", rd, 32'h33);
    bus_read(A_DATA, rd); check("rx_rd_empty", rd, 0);
    bus_read(A_STAT, rd); check("rx_ne_clear", rd, 32'h44);

    // Full RX: push and pop land on the same edge.
    for (int i = 0; i < RX_DEPTH; i++) rx_inject(8'(8'h60 + i));
    bus_read(A_STAT, rd); check("rx_full_status", rd, 32'h47);
    @(negedge clk);
    uart_rx_data = 8'h99; uart_rx_valid = 1'b1; bus_addr = A_DATA; bus_re = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0; bus_re = 1'b0; bus_addr = '0;
    check("rx_full_pushpop_head", bus_rdata, 32'h60);
    bus_read(A_STAT, rd); check("rx_full_pushpop_status", rd, 32'h47);
    for (int i = 1; i < RX_DEPTH; i++) begin
      bus_read(A_DATA, rd); check("rx_full_drain", rd, 32'(8'h60 + i));
    end
    bus_read(A_DATA, rd); check("rx_tail_99", rd, 32'h99);
    bus_read(A_DATA, rd); check("rx_after_drain", rd, 0);

    // Register access table.
    vt.push_back('{LED_ADDR, 32'hFFFF_ABCD, 1, 0, 1, 32'h0, 16'hABCD});
    vt.push_back('{LED_ADDR, 32'h0, 0, 1, 1, 32'h0000_ABCD, 16'hABCD});
    vt.push_back('{32'h1000_0010, 32'h1234_5678, 1, 0, 0, 32'h0, 16'hABCD});
    vt.push_back('{32'h1000_0010, 32'h0, 0, 1, 0, 32'h0, 16'hABCD});
    vt.push_back('{32'h0FFF_FFFC, 32'h0, 0, 1, 0, 32'h0, 16'hABCD});
    vt.push_back('{LED_ADDR + 4, 32'h0, 0, 1, 0, 32'h0, 16'hABCD});
    vt.push_back('{A_CTRL, 32'h2, 1, 0, 1, 32'h0, 16'hABCD});
    vt.push_back('{A_CTRL, 32'h0, 0, 1, 1, 32'h2, 16'hABCD});
    vt.push_back('{A_CTRL, 32'h0, 1, 1, 1, 32'h0, 16'hABCD});
    vt.push_back('{A_CTRL, 32'h0, 0, 1, 1, 32'h0, 16'hABCD});
    vt.push_back('{A_CLR, 32'h0, 0, 1, 1, 32'h0, 16'hABCD});
    vt.push_back('{A_STAT, 32'h0, 0, 1, 1, 32'h44, 16'hABCD});
    vt.push_back('{LED_ADDR, 32'h0000_1234, 1, 1, 1, 32'h0, 16'h1234});
    vt.push_back('{LED_ADDR, 32'h0, 0, 1, 1, 32'h0000_1234, 16'h1234});
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      bus_addr = vt[i].addr; bus_wdata = vt[i].wdata;
      bus_we = vt[i].we; bus_re = vt[i].re;
      #1 check($sformatf("vec%0d_hit", i), 32'(bus_hit), 32'(vt[i].exp_hit));
      @(negedge clk);
      bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0;
      check($sformatf("vec%0d_rdata", i), bus_rdata, vt[i].exp_rdata);
      check($sformatf("vec%0d_led", i), 32'(led_out), 32'(vt[i].exp_led));
    end

    // RX interrupt: registered one cycle after the push edge.
    bus_write(A_CTRL, 32'h1);
    @(negedge clk);
    check("irq_idle", 32'(irq), 0);
    @(negedge clk);
    uart_rx_data = 8'h5A; uart_rx_valid = 1'b1;
    @(negedge clk);
    uart_rx_valid = 1'b0;
    check("irq_push_cycle", 32'(irq), 0);
    check("rx_re_next_cycle", 32'(uart_rx_re), 1);
    @(negedge clk);
    check("irq_after_push", 32'(irq), 1);
    check("rx_re_one_cycle", 32'(uart_rx_re), 0);
    bus_read(A_DATA, rd); check("irq_byte", rd, 32'h5A);
    bus_write(A_CTRL, 32'h0);

    // Randomized phase with transmitter held busy.
    uart_tx_busy = 1'b1;
    movf = 0; movr = 0; n_inj = 0;
    re0 = rx_re_cnt;
    base = tx_seen.size();
    for (int k = 0; k < 300; k++) begin
      int op;
      logic [7:0] b;
      op = $urandom_range(0, 9);
      b = 8'($urandom);
      if (op <= 1) begin
        bus_write(A_DATA, {24'($urandom), b});
        if (mtx.size() < TX_DEPTH) mtx.push_back(b); else movf = 1;
      end else if (op <= 5) begin
        rx_inject(b);
        n_inj++;
        if (mrx.size() < RX_DEPTH) mrx.push_back(b); else movr = 1;
      end else if (op <= 7) begin
        bus_read(A_DATA, rd);
        check("rand_data", rd, (mrx.size() == 0) ? 32'h0 : 32'(mrx.pop_front()));
      end else if (op == 8) begin
        bus_read(A_STAT, rd);
        check("rand_status", rd, model_status(mtx.size(), mrx.size(), movf, movr));
      end else begin
        logic [31:0] c;
        c = 32'($urandom_range(0, 3)) << 4;
        bus_write(A_CLR, c);
        if (c[4]) movf = 0;
        if (c[5]) movr = 0;
      end
    end
    @(negedge clk);
    check("rand_rx_re_count", rx_re_cnt - re0, n_inj);
    check("rand_no_strobe", tx_seen.size(), base);
    uart_tx_busy = 1'b0;
    wait_strobes(base + mtx.size(), 20 * TX_DEPTH);
    for (int i = 0; i < mtx.size(); i++)
      if (base + i < tx_seen.size()) check("rand_tx_order", 32'(tx_seen[base+i]), 32'(mtx[i]));
    mtx.delete();
    repeat (5) @(negedge clk);
    bus_read(A_STAT, rd);
    check("rand_final_status", rd, model_status(0, mrx.size(), movf, movr));
    while (mrx.size() != 0) begin
      bus_read(A_DATA, rd); check("rand_rx_drain", rd, 32'(mrx.pop_front()));
    end

    // Reset asserted during a transmit strobe.
    uart_tx_busy = 1'b1;
    bus_write(A_DATA, 32'hA1); bus_write(A_DATA, 32'hA2); bus_write(A_DATA, 32'hA3);
    bus_write(A_CTRL, 32'h3);
    uart_tx_busy = 1'b0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!uart_tx_we && n < 30);
    end
    check("rst_test_pulse_seen", 32'(uart_tx_we), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_tx_we", 32'(uart_tx_we), 0);
    check("arst_tx_data", 32'(uart_tx_data), 0);
    check("arst_rx_re", 32'(uart_rx_re), 0);
    check("arst_irq", 32'(irq), 0);
    check("arst_rdata", bus_rdata, 0);
    check("arst_led", 32'(led_out), 0);
    check("arst_hit", 32'(bus_hit), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = tx_seen.size();
    repeat (30) @(negedge clk);
    check("no_strobe_after_rst", tx_seen.size(), base);
    bus_read(A_STAT, rd); check("status_after_rst", rd, 32'h44);
    bus_read(A_CTRL, rd); check("ctrl_after_rst", rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
